// File: rtl/sort_delay_queue.sv
// Timed eject-decision FIFO: holds each nonzero class for its belt travel delay and
// presents it for exactly one cycle when due. Optional late-fire counter: SORT_Q_LATE_CNT_EN.
module sort_delay_queue #(
    parameter int DEPTH     = 8,
    parameter int TW        = 16,
    parameter int MIN_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       det_valid,
    input  logic [1:0]                 det_class,
    input  logic [TW-1:0]              delay_cycles,
    input  logic                       clr_ovf,
    output logic [1:0]                 sigout_class,
    output logic                       fire,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
`ifdef SORT_Q_LATE_CNT_EN
    output logic [15:0]                late_cnt,
`endif
    output logic                       ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    r_cls [DEPTH];
    logic [TW-1:0] r_due [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_timer;
    logic          r_full;
    logic          r_ovf;
    logic          r_fire;
    logic [1:0]    r_sig;

    logic [TW-1:0] w_eff_delay;
    logic [TW-1:0] w_timer_nx;
    logic [TW-1:0] w_d;
    logic          w_pop;
    logic          w_try_push;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nx;

    // The head is tested against the timer value of the fire cycle, so the
    // registered output lands exactly on the due cycle; sign of the difference is wrap-safe.
    always_comb begin
        w_eff_delay = (delay_cycles < TW'(MIN_DELAY)) ? TW'(MIN_DELAY) : delay_cycles;
        w_timer_nx  = r_timer + 1'b1;
        w_d         = w_timer_nx - r_due[r_rd];
        w_pop       = en && (r_count != '0) && ($signed(w_d) >= 0);
        w_try_push  = en && det_valid && (det_class != 2'd0);
        w_push      = w_try_push && (!r_full || w_pop);
        w_drop      = w_try_push && r_full && !w_pop;
        w_count_nx  = r_count + CW'(w_push) - CW'(w_pop);
    end

    // NOTE: queue storage carries no reset; occupancy and pointers alone decide validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_cls[r_wr] <= det_class;
            r_due[r_wr] <= r_timer + w_eff_delay;
        end
    end

    // NOTE: all state updates are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_sig   <= 2'd0;
            r_fire  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (!en) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
                r_sig   <= 2'd0;
                r_fire  <= 1'b0;
            end else begin
                r_timer <= w_timer_nx;
                r_rd    <= r_rd + AW'(w_pop);
                r_wr    <= r_wr + AW'(w_push);
                r_count <= w_count_nx;
                r_full  <= (w_count_nx == CW'(DEPTH));
                r_sig   <= w_pop ? r_cls[r_rd] : 2'd0;
                r_fire  <= w_pop;
            end
            // A coincident drop outranks the clear so no loss goes unreported.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (clr_ovf)
                r_ovf <= 1'b0;
        end
    end

`ifdef SORT_Q_LATE_CNT_EN
    logic [15:0] r_late_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr_ovf)
            r_late_cnt <= '0;
        else if (w_pop && (w_d != '0) && (r_late_cnt != 16'hFFFF))
            r_late_cnt <= r_late_cnt + 16'd1;
    end

    assign late_cnt = r_late_cnt;
`endif

    assign sigout_class = r_sig;
    assign fire         = r_fire;
    assign count        = r_count;
    assign full         = r_full;
    assign ovf          = r_ovf;
endmodule

// File: tb/tb_sort_delay_queue.sv
// Directed bench for sort_delay_queue (TW=8 so the timer wraps often); every cycle's
// fire/class is compared against a hand-built table of expected fire cycles.
module tb_sort_delay_queue;
    localparam int DEPTH = 8;
    localparam int TW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          det_valid;
    logic [1:0]    det_class;
    logic [TW-1:0] delay_cycles;
    logic          clr_ovf;
    logic [1:0]    sigout_class;
    logic          fire;
    logic [3:0]    count;
    logic          full;
    logic          ovf;
`ifdef SORT_Q_LATE_CNT_EN
    logic [15:0]   late_cnt;
`endif

    sort_delay_queue #(.DEPTH(DEPTH), .TW(TW), .MIN_DELAY(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .det_valid    (det_valid),
        .det_class    (det_class),
        .delay_cycles (delay_cycles),
        .clr_ovf      (clr_ovf),
        .sigout_class (sigout_class),
        .fire         (fire),
        .count        (count),
        .full         (full),
`ifdef SORT_Q_LATE_CNT_EN
        .late_cnt     (late_cnt),
`endif
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [7:0]  tmr   = 8'd0;
    logic [1:0]  exp_cls [int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock; the expected-fire table is checked in every cycle.
    task automatic step();
        logic       was_rst;
        logic       was_en;
        logic [1:0] e;
        was_rst = rst;
        was_en  = en;
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst)     tmr = 8'd0;
        else if (was_en) tmr = tmr + 8'd1;
        e = exp_cls.exists(cyc) ? exp_cls[cyc] : 2'd0;
        check("sigout_class", 32'(sigout_class), 32'(e));
        check("fire", 32'(fire), 32'(e != 2'd0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [1:0] c, input int d, input bit expect_fire);
        det_valid    = 1'b1;
        det_class    = c;
        delay_cycles = 8'(d);
        if (expect_fire) exp_cls[cyc + ((d < 2) ? 2 : d)] = c;
        step();
        det_valid = 1'b0;
        det_class = 2'd0;
    endtask

    int c0;

    initial begin
        rst = 1'b1; en = 1'b1; det_valid = 1'b0; det_class = 2'd0;
        delay_cycles = '0; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sig", 32'(sigout_class), 32'd0);
        check("rst_fire", 32'(fire), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        cyc = 0;
        tmr = 8'd0;

        // Basic latency: class 2, delay 10
        run(5);
        push(2'd2, 10, 1'b1);
        check("basic_count1", 32'(count), 32'd1);
        run(9);
        check("basic_count0", 32'(count), 32'd0);
        run(5);

        // Clamp to MIN_DELAY and pass class
        push(2'd3, 0, 1'b1);
        run(4);
        push(2'd0, 7, 1'b0);
        check("pass_count", 32'(count), 32'd0);
        run(10);

        // Contention: head with later due blocks an already-due younger entry
        c0 = cyc;
        exp_cls[c0 + 30] = 2'd1;
        exp_cls[c0 + 31] = 2'd2;
        push(2'd1, 30, 1'b0);
        push(2'd2, 5, 1'b0);
        check("cont_count", 32'(count), 32'd2);
        run(35);
`ifdef SORT_Q_LATE_CNT_EN
        check("late_cnt_one", 32'(late_cnt), 32'd1);
`endif

        // Timer wrap: push at timer 250, fire lands across the wrap
        for (int i = 0; i < 300 && tmr != 8'd250; i++) step();
        push(2'd1, 20, 1'b1);
        run(25);

        // Overflow: 9 pushes into an 8-deep queue
        c0 = cyc;
        for (int i = 0; i < 8; i++) push(2'((i % 3) + 1), 100, 1'b1);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count8", 32'(count), 32'd8);
        push(2'd3, 100, 1'b0);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_count_hold", 32'(count), 32'd8);
        clr_ovf = 1'b1;
        push(2'd2, 100, 1'b0);
        check("ovf_clr_vs_drop", 32'(ovf), 32'd1);
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
`ifdef SORT_Q_LATE_CNT_EN
        check("late_cnt_clr", 32'(late_cnt), 32'd0);
`endif
        // Push while full lands on the head's pop cycle and is accepted
        while (cyc < c0 + 99) step();
        push(2'd1, 100, 1'b1);
        check("full_pop_count", 32'(count), 32'd8);
        check("full_pop_full", 32'(full), 32'd1);
        run(8);
        check("drain_count1", 32'(count), 32'd1);
        while (cyc < c0 + 205) step();
        check("drain_count0", 32'(count), 32'd0);

        // Flush via en low for one cycle
        for (int i = 0; i < 4; i++) push(2'(i % 3 + 1), 50, 1'b0);
        run(3);
        check("flush_pre_count", 32'(count), 32'd4);
        en = 1'b0;
        push(2'd2, 5, 1'b0);
        en = 1'b1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_full", 32'(full), 32'd0);
        run(60);
        check("flush_after", 32'(count), 32'd0);

        // Reset with an entry due in the cycle right after reset
        push(2'd3, 4, 1'b0);
        push(2'd1, 20, 1'b0);
        push(2'd2, 20, 1'b0);
        check("rst_pre_count", 32'(count), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_fire", 32'(fire), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        run(30);
        check("mid_rst_after", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
